// File: rtl/line_window_pkg.sv
// Shared defaults, fill-phase enum and tap-indexing helpers for line_window_buffer.
package line_window_pkg;

  localparam int LWB_PIXEL_WIDTH = 8;
  localparam int LWB_CHANNELS    = 1;
  localparam int LWB_LINE_WIDTH  = 1920;
  localparam int LWB_NUM_LINES   = 3;

  typedef enum logic {
    FILL_PRIMING   = 1'b0,
    FILL_STREAMING = 1'b1
  } fill_phase_e;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Line k rows back lives k slots behind the slot about to be overwritten.
  function automatic int tap_slot(input int tap, input int wr_ptr, input int num_mem);
    return (wr_ptr + num_mem - tap) % num_mem;
  endfunction

endpackage

// File: rtl/line_window_ram.sv
// One line of pixel storage: LINE_WIDTH x DW, registered read-before-write port.
module line_window_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 1920,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // The read register returns the pre-write contents; only it is cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/line_window_buffer.sv
// Streaming vertical-window line buffer: one NUM_LINES-tall column per accepted pixel.
// Optional macro LWB_BORDER_REPLICATE_EN emits from the first row, replicating the oldest valid row.
module line_window_buffer
  import line_window_pkg::*;
#(
  parameter  int PIXEL_WIDTH = LWB_PIXEL_WIDTH,
  parameter  int CHANNELS    = LWB_CHANNELS,
  parameter  int LINE_WIDTH  = LWB_LINE_WIDTH,
  parameter  int NUM_LINES   = LWB_NUM_LINES,
  localparam int DW          = PIXEL_WIDTH * CHANNELS,
  localparam int CW          = $clog2(LINE_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DW-1:0]           s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    s_sof,
  output logic [NUM_LINES*DW-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [CW-1:0]           m_col,
  output logic                    m_eol,
  output logic                    primed
);

  localparam int NUM_MEM = NUM_LINES - 1;
  localparam int PW      = idx_width(NUM_MEM);
  localparam int FW      = $clog2(NUM_LINES);

  localparam logic [CW-1:0] LAST_COL = CW'(LINE_WIDTH - 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(NUM_LINES - 2);
  localparam logic [FW-1:0] FILL_MAX = FW'(NUM_LINES - 1);

  typedef logic [DW-1:0]           beat_t;
  typedef beat_t [NUM_LINES-1:0]   window_t;

  logic [CW-1:0] wr_col;
  logic [PW-1:0] wr_ptr;
  logic [FW-1:0] lines_filled;
  logic [CW-1:0] col_eff;
  logic [PW-1:0] ptr_eff;
  logic [FW-1:0] filled_eff;
  logic          accept;
  logic          out_en;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] slot;
  beat_t         cur_q;
  beat_t         ram_q [NUM_MEM];
  window_t       window;
  fill_phase_e   phase;

  assign s_ready = !rst && (!m_valid || m_ready);
  assign accept  = s_valid && s_ready;

  // A start-of-frame beat restarts all counters before it is written.
  always_comb begin
    col_eff    = wr_col;
    ptr_eff    = wr_ptr;
    filled_eff = lines_filled;
    if (s_sof) begin
      col_eff    = '0;
      ptr_eff    = '0;
      filled_eff = '0;
    end
  end

`ifdef LWB_BORDER_REPLICATE_EN
  assign out_en = 1'b1;
`else
  assign out_en = (filled_eff == FILL_MAX);
`endif

  assign phase  = (lines_filled == FILL_MAX) ? FILL_STREAMING : FILL_PRIMING;
  assign primed = (phase == FILL_STREAMING);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_col       <= '0;
      wr_ptr       <= '0;
      lines_filled <= '0;
    end else if (accept) begin
      if (col_eff == LAST_COL) begin
        wr_col       <= '0;
        wr_ptr       <= (ptr_eff == LAST_PTR) ? '0 : ptr_eff + 1'b1;
        lines_filled <= (filled_eff == FILL_MAX) ? filled_eff : filled_eff + 1'b1;
      end else begin
        wr_col       <= col_eff + 1'b1;
        wr_ptr       <= ptr_eff;
        lines_filled <= filled_eff;
      end
    end
  end

  for (genvar i = 0; i < NUM_MEM; i++) begin : g_line
    line_window_ram #(
      .DW    (DW),
      .DEPTH (LINE_WIDTH),
      .AW    (CW)
    ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .en    (accept),
      .we    (ptr_eff == PW'(i)),
      .addr  (col_eff),
      .wdata (s_data),
      .rdata (ram_q[i])
    );
  end

  // RAM read registers already hold old-row taps, so only the side info is captured here.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_col   <= '0;
      m_eol   <= 1'b0;
      cur_q   <= '0;
      ptr_q   <= '0;
    end else if (accept) begin
      m_valid <= out_en;
      m_col   <= col_eff;
      m_eol   <= (col_eff == LAST_COL);
      cur_q   <= s_data;
      ptr_q   <= ptr_eff;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef LWB_BORDER_REPLICATE_EN
  logic [FW-1:0] filled_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      filled_q <= '0;
    end else if (accept) begin
      filled_q <= filled_eff;
    end
  end
`endif

  always_comb begin
    slot      = '0;
    window    = '0;
    window[0] = cur_q;
    for (int k = 1; k < NUM_LINES; k++) begin
      slot      = PW'(tap_slot(k, int'(ptr_q), NUM_MEM));
      window[k] = ram_q[slot];
`ifdef LWB_BORDER_REPLICATE_EN
      if (FW'(k) > filled_q) begin
        window[k] = window[k-1];
      end
`endif
    end
  end

  assign m_data = window;

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer: a 4x3 mono instance and a 5x5 RGB instance.
module tb_line_window_buffer;

  localparam int LW_A = 4;
  localparam int NL_A = 3;
  localparam int LW_B = 5;
  localparam int NL_B = 5;

`ifdef LWB_BORDER_REPLICATE_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  logic [7:0]   a_s_data;
  logic         a_s_valid, a_s_ready, a_s_sof;
  logic [23:0]  a_m_data;
  logic         a_m_valid, a_m_ready, a_m_eol, a_primed;
  logic [1:0]   a_m_col;

  logic [23:0]  b_s_data;
  logic         b_s_valid, b_s_ready, b_s_sof;
  logic [119:0] b_m_data;
  logic         b_m_valid, b_m_ready, b_m_eol, b_primed;
  logic [2:0]   b_m_col;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  line_window_buffer #(
    .PIXEL_WIDTH (8),
    .CHANNELS    (1),
    .LINE_WIDTH  (LW_A),
    .NUM_LINES   (NL_A)
  ) u_dut_a (
    .clk     (clk),
    .rst     (rst),
    .s_data  (a_s_data),
    .s_valid (a_s_valid),
    .s_ready (a_s_ready),
    .s_sof   (a_s_sof),
    .m_data  (a_m_data),
    .m_valid (a_m_valid),
    .m_ready (a_m_ready),
    .m_col   (a_m_col),
    .m_eol   (a_m_eol),
    .primed  (a_primed)
  );

  line_window_buffer #(
    .PIXEL_WIDTH (8),
    .CHANNELS    (3),
    .LINE_WIDTH  (LW_B),
    .NUM_LINES   (NL_B)
  ) u_dut_b (
    .clk     (clk),
    .rst     (rst),
    .s_data  (b_s_data),
    .s_valid (b_s_valid),
    .s_ready (b_s_ready),
    .s_sof   (b_s_sof),
    .m_data  (b_m_data),
    .m_valid (b_m_valid),
    .m_ready (b_m_ready),
    .m_col   (b_m_col),
    .m_eol   (b_m_eol),
    .primed  (b_primed)
  );

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle on the selected instance and sample 1 time unit after the edge.
  task automatic applyStimulus(input bit sel_b, input logic [23:0] data, input bit valid,
                               input bit sof, input bit ready);
    if (sel_b) begin
      b_s_data  = data;
      b_s_valid = valid;
      b_s_sof   = sof;
      b_m_ready = ready;
      a_s_valid = 1'b0;
      a_s_sof   = 1'b0;
      a_m_ready = 1'b1;
    end else begin
      a_s_data  = data[7:0];
      a_s_valid = valid;
      a_s_sof   = sof;
      a_m_ready = ready;
      b_s_valid = 1'b0;
      b_s_sof   = 1'b0;
      b_m_ready = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pix_a(input int base, input int r, input int c);
    return 8'(base + 16 * r + c);
  endfunction

  function automatic logic [23:0] pix_b(input int r, input int c);
    int p;
    p = 16 * r + c;
    return {8'(p + 128), 8'(p + 64), 8'(p)};
  endfunction

  // Rows before the frame start clamp to row 0; only observed when border replication is on.
  function automatic logic [23:0] exp_a(input int base, input int r, input int c);
    logic [23:0] w;
    int rr;
    w = '0;
    for (int k = 0; k < NL_A; k++) begin
      rr = (r - k < 0) ? 0 : r - k;
      w[k*8 +: 8] = pix_a(base, rr, c);
    end
    return w;
  endfunction

  function automatic logic [119:0] exp_b(input int r, input int c);
    logic [119:0] w;
    int rr;
    w = '0;
    for (int k = 0; k < NL_B; k++) begin
      rr = (r - k < 0) ? 0 : r - k;
      w[k*24 +: 24] = pix_b(rr, c);
    end
    return w;
  endfunction

  task automatic checkBeatA(input string pre, input int base, input int r, input int c);
    bit ev;
    int done;
    ev   = BORDER || (r >= NL_A - 1);
    done = r + ((c == LW_A - 1) ? 1 : 0);
    checkOutput($sformatf("%s r%0d c%0d valid", pre, r, c), a_m_valid, ev);
    if (ev) begin
      checkOutput($sformatf("%s r%0d c%0d data", pre, r, c), a_m_data, exp_a(base, r, c));
      checkOutput($sformatf("%s r%0d c%0d col", pre, r, c), a_m_col, c);
      checkOutput($sformatf("%s r%0d c%0d eol", pre, r, c), a_m_eol, (c == LW_A - 1));
    end
    checkOutput($sformatf("%s r%0d c%0d primed", pre, r, c), a_primed, (done >= NL_A - 1));
  endtask

  task automatic sendBeatA(input string pre, input int base, input int r, input int c, input bit sof);
    applyStimulus(1'b0, 24'(pix_a(base, r, c)), 1'b1, sof, 1'b1);
    checkBeatA(pre, base, r, c);
  endtask

  task automatic checkBeatB(input int r, input int c);
    bit ev;
    int done;
    ev   = BORDER || (r >= NL_B - 1);
    done = r + ((c == LW_B - 1) ? 1 : 0);
    checkOutput($sformatf("t5 r%0d c%0d valid", r, c), b_m_valid, ev);
    if (ev) begin
      checkOutput($sformatf("t5 r%0d c%0d data", r, c), b_m_data, exp_b(r, c));
      checkOutput($sformatf("t5 r%0d c%0d col", r, c), b_m_col, c);
      checkOutput($sformatf("t5 r%0d c%0d eol", r, c), b_m_eol, (c == LW_B - 1));
    end
    checkOutput($sformatf("t5 r%0d c%0d primed", r, c), b_primed, (done >= NL_B - 1));
  endtask

  initial begin
    rst       = 1'b1;
    a_s_data  = '0;
    a_s_valid = 1'b1;
    a_s_sof   = 1'b0;
    a_m_ready = 1'b1;
    b_s_data  = '0;
    b_s_valid = 1'b1;
    b_s_sof   = 1'b0;
    b_m_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst a_m_valid", a_m_valid, 1'b0);
    checkOutput("rst a_m_data", a_m_data, 24'h0);
    checkOutput("rst a_m_col", a_m_col, 2'd0);
    checkOutput("rst a_m_eol", a_m_eol, 1'b0);
    checkOutput("rst a_primed", a_primed, 1'b0);
    checkOutput("rst a_s_ready", a_s_ready, 1'b0);
    checkOutput("rst b_m_valid", b_m_valid, 1'b0);
    checkOutput("rst b_s_ready", b_s_ready, 1'b0);
    rst       = 1'b0;
    a_s_valid = 1'b0;
    b_s_valid = 1'b0;
    #1;
    checkOutput("idle a_s_ready", a_s_ready, 1'b1);

    $display("[TB] test 1: four-row stream");
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < LW_A; c++) begin
        sendBeatA("t1", 0, r, c, (r == 0) && (c == 0));
        if (r == 2 && c == 1) checkOutput("t1 r2c1 literal", a_m_data, 24'h011121);
        if (r == 3 && c == 3) checkOutput("t1 r3c3 literal", a_m_data, 24'h132333);
`ifdef LWB_BORDER_REPLICATE_EN
        if (r == 0 && c == 0) checkOutput("t6 r0c0 literal", a_m_data, 24'h000000);
        if (r == 1 && c == 2) checkOutput("t6 r1c2 literal", a_m_data, 24'h020212);
`endif
      end
    end
    applyStimulus(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("t1 idle m_valid", a_m_valid, 1'b0);

    $display("[TB] test 2: back-pressure mid row 2");
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < LW_A; c++) begin
        if (r == 2 && c == 2) begin
          for (int s = 0; s < 3; s++) begin
            applyStimulus(1'b0, 24'(pix_a(0, 2, 2)), 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("t2 stall%0d s_ready", s), a_s_ready, 1'b0);
            checkOutput($sformatf("t2 stall%0d m_valid", s), a_m_valid, 1'b1);
            checkOutput($sformatf("t2 stall%0d m_data", s), a_m_data, exp_a(0, 2, 1));
            checkOutput($sformatf("t2 stall%0d m_col", s), a_m_col, 2'd1);
          end
        end
        sendBeatA("t2", 0, r, c, (r == 0) && (c == 0));
      end
    end

    $display("[TB] test 3: sof abort at row 3 col 2");
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < LW_A; c++) begin
        if (r < 3 || c < 2) sendBeatA("t3old", 0, r, c, (r == 0) && (c == 0));
      end
    end
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < LW_A; c++) begin
        sendBeatA("t3new", 8'h80, r, c, (r == 0) && (c == 0));
      end
    end

    $display("[TB] test 4: reset at row 2 col 2");
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < LW_A; c++) begin
        if (r < 2 || c < 2) sendBeatA("t4pre", 0, r, c, (r == 0) && (c == 0));
      end
    end
    rst       = 1'b1;
    a_s_data  = pix_a(0, 2, 2);
    a_s_valid = 1'b1;
    #1;
    checkOutput("t4 rst s_ready", a_s_ready, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("t4 rst m_valid", a_m_valid, 1'b0);
    checkOutput("t4 rst primed", a_primed, 1'b0);
    checkOutput("t4 rst m_col", a_m_col, 2'd0);
    rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < LW_A; c++) begin
        sendBeatA("t4post", 0, r, c, 1'b0);
      end
    end

    $display("[TB] test 5: three channels, five taps");
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < LW_B; c++) begin
        applyStimulus(1'b1, pix_b(r, c), 1'b1, (r == 0) && (c == 0), 1'b1);
        checkBeatB(r, c);
        if (r == 4 && c == 0) begin
          checkOutput("t5 r4c0 literal", b_m_data, 120'h804000_905010_a06020_b07030_c08040);
        end
      end
    end
    applyStimulus(1'b1, 24'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("t5 idle m_valid", b_m_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_window_buffer.md
Name: line_window_buffer

Overview:
Streaming vertical-window line buffer that is the next generation of the team's single-line-select line buffer. It accepts a raster pixel stream with valid/ready handshake and start-of-frame marker. Each accepted pixel produces one output column of NUM_LINES vertically aligned pixels (current row plus NUM_LINES-1 previous rows) at the same column. It sits between the sensor/DMA pixel stream and the convolution/interpolation kernels, and supports multi-channel pixels, back-pressure and frame restart.

Parameters:
PIXEL_WIDTH, 8, bits per channel
CHANNELS, 1, channels per pixel (e.g. 3 for RGB); beat width DW = PIXEL_WIDTH*CHANNELS
LINE_WIDTH, 1920, pixels per line; must be >= 2
NUM_LINES, 3, window height in rows (taps); must be >= 2; NUM_LINES-1 line memories are stored

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  reset: one clock; reset is synchronous and active-high
s_data  in  DW  input pixel, channel 0 in LSBs
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid && s_ready
s_sof  in  1  qualifies the first pixel of a frame
m_data  out  NUM_LINES*DW  window column; tap 0 (LSBs) = current row, tap NUM_LINES-1 = oldest row
m_valid  out  1  output column valid
m_ready  in  1  downstream accept
m_col  out  $clog2(LINE_WIDTH)  column index of m_data
m_eol  out  1  m_data is the last column of a line
primed  out  1  NUM_LINES-1 complete lines stored since the last sof/reset

Behaviour:
- Reset, sampled on a clock edge with rst=1: m_valid=0, m_data=0, m_col=0, m_eol=0, primed=0. Internal wr_col=0, line rotation pointer=0, lines_filled=0. s_ready=0 while rst=1. Reset mid-line discards all stored lines. Memory contents are not cleared.
- Handshake: one-entry registered output. s_ready = !rst && (!m_valid || m_ready). m_data, m_col and m_eol hold stable while m_valid && !m_ready.
- Accept (s_valid && s_ready) at column c:
  - Memory read of all NUM_LINES-1 lines at c happens before the write to the oldest line slot at c (read-before-write, same cycle).
  - Next edge: m_data <= {line_{N-1}[c] .. line_1[c], s_data}, m_col <= c, m_eol <= (c==LINE_WIDTH-1).
  - m_valid <= primed_eff, where primed_eff = (lines_filled==NUM_LINES-1). A non-primed beat is consumed with no output.
- Latency: 1 cycle from accept to m_valid. Throughput: 1 column/cycle with m_ready held high.
- No accept && m_ready: m_valid <= 0.
- Column wrap: at c==LINE_WIDTH-1, wr_col <= 0, the rotation pointer advances (modulo NUM_LINES-1, so the newest line becomes line_1), and lines_filled increments, saturating at NUM_LINES-1. primed mirrors lines_filled==NUM_LINES-1.
- s_sof on an accepted beat: the beat is treated as column 0. lines_filled, rotation pointer and the column counter restart, so that beat writes col 0 and wr_col becomes 1. Its output is suppressed (not primed). sof mid-line is a legal abort; partial-line data is discarded.
- No state machine beyond these counters: PRIMING (lines_filled<N-1) -> STREAMING on the line wrap that fills, and -> PRIMING on sof or rst.
- Widths: all counter compares are against LINE_WIDTH-1 and NUM_LINES-2 exactly. Non-power-of-two sizes must wrap correctly.

Optional Feature:
LWB_BORDER_REPLICATE_EN
- Defined: output is produced from the first line of a frame (m_valid on every accepted beat). Taps referring to rows not yet received replicate the oldest valid row; for row 0, all taps equal s_data. primed still reports true fill state.
- Undefined: outputs are suppressed until primed, as above.

Decomposition:
- Package line_window_pkg: pixel beat typedef (DW-wide), window typedef (NUM_LINES x beat), localparams for column/pointer widths, helper function for tap indexing.
- One sub-module, line_window_ram: single line memory, LINE_WIDTH x DW, registered read-before-write port. Instantiated NUM_LINES-1 times under generate.
- Top-level holds counters, rotation mux and output register.

Test Plan:
All tests use PIXEL_WIDTH=8, CHANNELS=1, LINE_WIDTH=4, NUM_LINES=3.
1. Stream rows 0..3 with pixel=16*row+col, sof on the first beat, m_ready=1 -> no m_valid for rows 0-1. Row 2 col 1 outputs m_data={0x01,0x11,0x21}. Row 3 col 3 outputs {0x13,0x23,0x33} with m_eol=1.
2. Same stream, m_ready low for 3 cycles mid-row 2 -> s_ready=0 during the stall, m_data is stable, and no beats are lost or duplicated; m_col sequence is 0,1,2,3.
3. Assert s_sof at row 3 col 2 -> primed drops next cycle. Outputs resume only after 2 full new lines, and the new taps contain only new-frame data.
4. Assert rst at row 2 col 2 for 1 cycle -> m_valid=0 and s_ready=0 during reset. The restarted stream behaves as in test 1.
5. Repeat the test 1 stream with CHANNELS=3, NUM_LINES=5, LINE_WIDTH=5 -> channel packing is preserved per tap. First output is at row 4 col 0; tap order is newest→oldest.
6. Repeat test 1 with LWB_BORDER_REPLICATE_EN defined -> row 0 col 0 outputs {0x00,0x00,0x00}. Row 1 col 2 outputs {0x02,0x02,0x12}.
